uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one shared uart_tx serializer from NUM_REQ byte requesters.
// Define UART_ARB_STRICT_PRIO_EN to replace round-robin with fixed lowest-index priority.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_parity_en,
  input  logic [NUM_REQ-1:0]   req_even_parity,
  output logic                 tx_start,
  output logic [7:0]           data_in,
  output logic                 parity_en,
  output logic                 even_parity,
  input  logic                 tx_busy,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 frame_done,
  output logic                 start_err
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW   = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_reg;
  logic               tx_start_reg;
  logic [7:0]         data_reg;
  logic               parity_en_reg;
  logic               even_parity_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic               frame_done_reg;
  logic               start_err_reg;
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      cnt_next;
`ifndef UART_ARB_STRICT_PRIO_EN
  logic [IDXW-1:0]    last_reg;
`endif

  logic [7:0]         req_byte [NUM_REQ];
  logic               win_valid;
  logic [IDXW-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

`ifdef UART_ARB_STRICT_PRIO_EN
  // Scan downward so the lowest valid index is the last one written.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[IDXW'(k)]) begin
        win_valid = 1'b1;
        win_idx   = IDXW'(k);
      end
    end
  end
`else
  // last_reg <= NUM_REQ-1, so a single conditional subtract performs the wrap.
  always_comb begin
    int cand;
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_reg) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_valid && req_valid[IDXW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = IDXW'(cand);
      end
    end
  end
`endif

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign accept    = (state_reg == IDLE) && !rst && !tx_busy && win_valid;
  assign req_ready = accept ? win_onehot : '0;
  assign cnt_next  = cnt_reg + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      tx_start_reg    <= 1'b0;
      data_reg        <= '0;
      parity_en_reg   <= 1'b0;
      even_parity_reg <= 1'b0;
      grant_reg       <= '0;
      frame_done_reg  <= 1'b0;
      start_err_reg   <= 1'b0;
      cnt_reg         <= '0;
`ifndef UART_ARB_STRICT_PRIO_EN
      last_reg        <= IDXW'(NUM_REQ - 1);
`endif
    end else begin
      tx_start_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
      start_err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            data_reg        <= req_byte[win_idx];
            parity_en_reg   <= req_parity_en[win_idx];
            even_parity_reg <= req_even_parity[win_idx];
            grant_reg       <= win_onehot;
`ifndef UART_ARB_STRICT_PRIO_EN
            last_reg        <= win_idx;
`endif
            tx_start_reg    <= 1'b1;
            state_reg       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= '0;
          state_reg <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_reg <= WAIT_DONE;
          end else begin
            cnt_reg <= cnt_next;
            if (cnt_next == CW'(BUSY_TIMEOUT)) begin
              start_err_reg <= 1'b1;
              grant_reg     <= '0;
              state_reg     <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            frame_done_reg <= 1'b1;
            grant_reg      <= '0;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign tx_start    = tx_start_reg;
  assign data_in     = data_reg;
  assign parity_en   = parity_en_reg;
  assign even_parity = even_parity_reg;
  assign grant       = grant_reg;
  assign frame_done  = frame_done_reg;
  assign start_err   = start_err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx busy model plus an arbitration reference model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_parity_en;
  logic [N-1:0]   req_even_parity;
  logic           tx_start;
  logic [7:0]     data_in;
  logic           parity_en;
  logic           even_parity;
  logic           tx_busy;
  logic [N-1:0]   grant;
  logic           frame_done;
  logic           start_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int ref_last;
  int frame_no = 0;

  // busy_mode: 0 = serializer model, 1 = stuck low, 2 = stuck high
  int          busy_mode = 0;
  int          cnt_m = 0;
  int          len_m = 10;
  logic [10:0] frame_m = '1;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_parity_en(req_parity_en), .req_even_parity(req_even_parity),
    .tx_start(tx_start), .data_in(data_in), .parity_en(parity_en),
    .even_parity(even_parity), .tx_busy(tx_busy), .grant(grant),
    .frame_done(frame_done), .start_err(start_err)
  );

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic pe, input logic ep);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (pe) f[9] = ep ? ^d : ~^d;
    return f;
  endfunction

  always @(posedge clk) begin
    if (tx_start) begin
      len_m   <= parity_en ? 11 : 10;
      cnt_m   <= parity_en ? 11 : 10;
      frame_m <= mk_frame(data_in, parity_en, even_parity);
    end else if (cnt_m > 0) begin
      cnt_m <= cnt_m - 1;
    end
  end

  assign tx_busy = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? 1'b0 : (cnt_m != 0);

  function automatic int ref_pick(input logic [N-1:0] v);
`ifdef UART_ARB_STRICT_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(ref_last + k) % N]) return (ref_last + k) % N;
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 0);
    chk({tag, "_data_in"}, 32'(data_in), 0);
    chk({tag, "_parity_en"}, 32'(parity_en), 0);
    chk({tag, "_even_parity"}, 32'(even_parity), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_start_err"}, 32'(start_err), 0);
  endtask

  task automatic do_reset;
    busy_mode = 0;
    req_valid = '0;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    ref_last = N - 1;
    for (int c = 0; c < 40 && tx_busy; c++) step;
    chk("idle_wait", 32'(tx_busy), 0);
  endtask

  // Starts in an IDLE cycle with inputs applied now; ends in the frame_done cycle.
  task automatic run_frame(input logic [N-1:0] v, input logic [8*N-1:0] d,
                           input logic [N-1:0] pe, input logic [N-1:0] ep, input logic check_par);
    int w, busy_n, exp_len;
    logic [N-1:0] exp_g;
    logic [7:0] exp_d;
    logic exp_pe, exp_ep, hold_ok, done, par_bit;
    req_valid = v; req_data = d; req_parity_en = pe; req_even_parity = ep;
    #1;
    w = ref_pick(v);
    exp_g = '0;
    exp_g[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_g));
    ref_last = w;
    exp_d = d[8*w +: 8];
    exp_pe = pe[w];
    exp_ep = ep[w];
    exp_len = exp_pe ? 11 : 10;
    step;
    chk("tx_start", 32'(tx_start), 1);
    chk("data_in", 32'(data_in), 32'(exp_d));
    chk("parity_cfg", 32'({parity_en, even_parity}), 32'({exp_pe, exp_ep}));
    chk("grant", 32'(grant), 32'(exp_g));
    req_data = {$urandom, $urandom};
    req_parity_en = N'($urandom);
    req_even_parity = N'($urandom);
    busy_n = 0; done = 1'b0; hold_ok = 1'b1; par_bit = 1'bx;
    for (int c = 0; c < 20 && !done; c++) begin
      step;
      if (tx_busy) begin
        busy_n++;
        if (len_m - cnt_m == 9) par_bit = frame_m[9];
        if (grant !== exp_g || data_in !== exp_d || parity_en !== exp_pe ||
            even_parity !== exp_ep || tx_start !== 1'b0 || req_ready !== '0 ||
            frame_done !== 1'b0) hold_ok = 1'b0;
      end else if (busy_n > 0) begin
        done = 1'b1;
        if (frame_done !== 1'b0 || grant !== exp_g) hold_ok = 1'b0;
      end
    end
    chk("busy_fall", 32'(done), 1);
    chk("frame_len", 32'(busy_n), 32'(exp_len));
    chk("hold", 32'(hold_ok), 1);
    if (check_par) chk("parity_bit", 32'(par_bit), 1);
    step;
    chk("frame_done", 32'(frame_done), 1);
    chk("grant_idle", 32'(grant), 0);
    $display("frame %0d: valid=%b winner=%0d data=%02h pe=%0d ep=%0d busy=%0d",
             frame_no, v, w, exp_d, exp_pe, exp_ep, busy_n);
    frame_no++;
  endtask

  initial begin
    logic [8*N-1:0] d;
    logic [N-1:0] v;
    logic err_seen, idle_ok;
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_parity_en = '0; req_even_parity = '0;
    ref_last = N - 1;
    step;
    step;
    check_reset_outputs("reset");
    rst = 1'b0;
    ref_last = N - 1;
    step;

    // Single request from requester 2, parity off.
    d = {$urandom, $urandom};
    d[23:16] = 8'hA5;
    run_frame(4'b0100, d, 4'b0000, 4'b0000, 1'b0);

    // Round-robin with all requesters continuously valid.
    do_reset;
    for (int i = 0; i < 5; i++) run_frame(4'b1111, {$urandom, $urandom}, 4'b0000, 4'b0000, 1'b0);

    // Parity passthrough: requester 1, 8'h55, odd parity.
    d = {$urandom, $urandom};
    d[15:8] = 8'h55;
    run_frame(4'b0010, d, 4'b0010, 4'b0000, 1'b1);

    // Requesters 0 and 3 both continuously valid.
    for (int i = 0; i < 3; i++) run_frame(4'b1001, {$urandom, $urandom}, 4'b1111, 4'b0101, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      run_frame(v, {$urandom, $urandom}, N'($urandom), N'($urandom), 1'b0);
    end

    // Timeout: tx_busy stuck low.
    do_reset;
    busy_mode = 1;
    req_valid = 4'b0011;
    #1;
    chk("to_ready0", 32'(req_ready), 32'b0001);
    step;
    chk("to_tx_start", 32'(tx_start), 1);
    err_seen = 1'b0;
    for (int c = 0; c < T; c++) begin
      step;
      err_seen = err_seen | start_err;
    end
    chk("to_early_err", 32'(err_seen), 0);
    step;
    chk("to_start_err", 32'(start_err), 1);
    chk("to_grant_clear", 32'(grant), 0);
    chk("to_ready1", 32'(req_ready), 32'b0010);
    $display("timeout: start_err=%0d next_ready=%b", start_err, req_ready);
    step;
    chk("to_regrant", 32'(grant), 32'b0010);
    chk("to_err_pulse", 32'(start_err), 0);
    do_reset;

    // Reset four cycles into a frame, then tx_busy held high by a stub.
    req_valid = 4'b0100;
    req_data = {$urandom, $urandom};
    req_parity_en = 4'b1111;
    req_even_parity = 4'b1111;
    #1;
    chk("mid_ready", 32'(req_ready), 32'b0100);
    step;
    for (int c = 0; c < 4; c++) step;
    chk("mid_busy", 32'(tx_busy), 1);
    busy_mode = 2;
    rst = 1'b1;
    step;
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    idle_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step;
      if (req_ready !== '0 || grant !== '0 || tx_start !== 1'b0) idle_ok = 1'b0;
    end
    chk("stub_busy_no_grant", 32'(idle_ok), 1);
    $display("reset mid-frame: held off grant for 5 busy cycles");
    req_valid = '0;
    busy_mode = 0;
    ref_last = N - 1;
    for (int c = 0; c < 20 && tx_busy; c++) step;
    run_frame(4'b0110, {$urandom, $urandom}, 4'b0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
